// File: rtl/alu_control_if.sv
// Decode-stage to ALU-control bus: ALUOp/funct in, registered ALU select and illegal flag out.
interface alu_control_if;
    logic       en;
    logic [1:0] alu_op;
    logic [5:0] funct;
    logic [3:0] alu_ctrl;
    logic       illegal;

    modport master (
        output en,
        output alu_op,
        output funct,
        input  alu_ctrl,
        input  illegal
    );

    modport slave (
        input  en,
        input  alu_op,
        input  funct,
        output alu_ctrl,
        output illegal
    );
endinterface

// File: rtl/alu_control.sv
// MIPS ALU control decoder: maps ALUOp plus funct[3:0] to a registered 4-bit ALU select,
// flagging encodings the ALU does not implement.
module alu_control #(
    parameter logic [3:0] RESET_CTRL   = 4'b0000,
    parameter logic [3:0] ILLEGAL_CTRL = 4'b1111
) (
    input logic         clk,
    input logic         rst_n,
    alu_control_if.slave bus
);

    localparam logic [1:0] OpMem   = 2'b00;
    localparam logic [1:0] OpBranch = 2'b01;
    localparam logic [1:0] OpRtype = 2'b10;

    localparam logic [3:0] CtrlAnd = 4'b0000;
    localparam logic [3:0] CtrlOr  = 4'b0001;
    localparam logic [3:0] CtrlAdd = 4'b0010;
    localparam logic [3:0] CtrlSub = 4'b0110;
    localparam logic [3:0] CtrlSlt = 4'b0111;
    localparam logic [3:0] CtrlNor = 4'b1100;

    logic [3:0] ctrl_d;
    logic [3:0] ctrl_q;
    logic       illegal_d;
    logic       illegal_q;
    logic [3:0] funct_lo;
    logic [3:0] rtype_ctrl;
    logic       rtype_illegal;

    // Only the low nibble is ever looked at, so X/Z on funct[5:4] cannot reach the outputs.
    assign funct_lo = bus.funct[3:0];

    always_comb begin
        rtype_ctrl    = ILLEGAL_CTRL;
        rtype_illegal = 1'b1;
        case (funct_lo)
            4'b0000: begin rtype_ctrl = CtrlAdd; rtype_illegal = 1'b0; end
            4'b0010: begin rtype_ctrl = CtrlSub; rtype_illegal = 1'b0; end
            4'b0100: begin rtype_ctrl = CtrlAnd; rtype_illegal = 1'b0; end
            4'b0101: begin rtype_ctrl = CtrlOr;  rtype_illegal = 1'b0; end
            4'b0111: begin rtype_ctrl = CtrlNor; rtype_illegal = 1'b0; end
            4'b1010: begin rtype_ctrl = CtrlSlt; rtype_illegal = 1'b0; end
            default: begin rtype_ctrl = ILLEGAL_CTRL; rtype_illegal = 1'b1; end
        endcase
    end

    // The R-type result is selected only for ALUOp 10, so funct X/Z is masked for 00/01.
    always_comb begin
        ctrl_d    = ILLEGAL_CTRL;
        illegal_d = 1'b1;
        case (bus.alu_op)
            OpMem: begin
                ctrl_d    = CtrlAdd;
                illegal_d = 1'b0;
            end
            OpBranch: begin
                ctrl_d    = CtrlSub;
                illegal_d = 1'b0;
            end
            OpRtype: begin
                ctrl_d    = rtype_ctrl;
                illegal_d = rtype_illegal;
            end
            default: begin
                ctrl_d    = ILLEGAL_CTRL;
                illegal_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q    <= RESET_CTRL;
            illegal_q <= 1'b0;
        end else if (bus.en) begin
            ctrl_q    <= ctrl_d;
            illegal_q <= illegal_d;
        end
    end

    assign bus.alu_ctrl = ctrl_q;
    assign bus.illegal  = illegal_q;

endmodule

// File: tb/tb_alu_control.sv
// Directed-vector bench for alu_control: reset, decode table, illegal encodings, hold, async reset.
module tb_alu_control;

    logic clk;
    logic rst_n;
    int   n_total;
    int   n_bad;

    alu_control_if bus ();

    alu_control #(
        .RESET_CTRL   (4'b0000),
        .ILLEGAL_CTRL (4'b1111)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    // Drive one vector, clock it in, then compare both outputs 1 time unit after the edge.
    task automatic step(input string tag, input logic [1:0] op, input logic [5:0] f,
                        input logic [3:0] exp_ctrl, input logic exp_ill);
        bus.alu_op = op;
        bus.funct  = f;
        @(posedge clk);
        #1;
        check({tag, ".ctrl"}, bus.alu_ctrl, exp_ctrl);
        check({tag, ".ill"}, {3'b000, bus.illegal}, {3'b000, exp_ill});
    endtask

    initial begin
        n_total    = 0;
        n_bad      = 0;
        rst_n      = 1'b0;
        bus.en     = 1'b0;
        bus.alu_op = 2'b00;
        bus.funct  = 6'b000000;

        // Reset is asynchronous: outputs valid before any clock edge.
        #2;
        check("rst.ctrl", bus.alu_ctrl, 4'b0000);
        check("rst.ill", {3'b000, bus.illegal}, 4'b0000);
        #1;
        rst_n  = 1'b1;
        bus.en = 1'b1;
        step("rel_add", 2'b00, {2'bxx, 4'b0000}, 4'b0010, 1'b0);

        // ALUOp 00/01 ignore funct.
        step("mem_f2", 2'b00, {2'bxx, 4'b0010}, 4'b0010, 1'b0);
        step("br_f0", 2'b01, {2'bxx, 4'b0000}, 4'b0110, 1'b0);
        step("br_f2", 2'b01, {2'bxx, 4'b0010}, 4'b0110, 1'b0);
        step("br_fx", 2'b01, 6'bxxxxxx, 4'b0110, 1'b0);

        // R-type sweep with an async reset pulse between edges.
        step("r_add", 2'b10, {2'bxx, 4'b0000}, 4'b0010, 1'b0);
        step("r_sub", 2'b10, {2'bxx, 4'b0010}, 4'b0110, 1'b0);
        step("r_and", 2'b10, {2'bxx, 4'b0100}, 4'b0000, 1'b0);
        step("r_or", 2'b10, {2'bxx, 4'b0101}, 4'b0001, 1'b0);
        rst_n = 1'b0;
        #1;
        check("mid_rst.ctrl", bus.alu_ctrl, 4'b0000);
        check("mid_rst.ill", {3'b000, bus.illegal}, 4'b0000);
        #1;
        rst_n = 1'b1;
        step("r_nor", 2'b10, {2'bxx, 4'b0111}, 4'b1100, 1'b0);
        step("r_slt", 2'b10, {2'bxx, 4'b1010}, 4'b0111, 1'b0);

        // Unsupported encodings.
        step("ill_r", 2'b10, 6'b100011, 4'b1111, 1'b1);
        step("ill_op3", 2'b11, 6'b100000, 4'b1111, 1'b1);
        step("ill_r1", 2'b10, 6'b001011, 4'b1111, 1'b1);

        // Hold: en low freezes outputs across edges.
        step("hold_load", 2'b10, 6'b100100, 4'b0000, 1'b0);
        bus.en = 1'b0;
        step("hold1", 2'b01, 6'b000000, 4'b0000, 1'b0);
        step("hold2", 2'b01, 6'b000000, 4'b0000, 1'b0);
        step("hold3", 2'b11, 6'b000000, 4'b0000, 1'b0);
        bus.en = 1'b1;
        step("hold_rel", 2'b01, 6'b000000, 4'b0110, 1'b0);

        // Reset overrides en and holds through an edge.
        rst_n = 1'b0;
        step("rst_edge", 2'b10, 6'b000010, 4'b0000, 1'b0);
        rst_n = 1'b1;
        step("post_rst", 2'b10, 6'b000010, 4'b0110, 1'b0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_control.md
Name: alu_control

Overview:
- MIPS single-cycle/pipelined ALU control decoder.
- Maps the 2-bit ALUOp from the main control unit plus the instruction funct field to the 4-bit ALU operation select.
- Output is registered and sits between the decode stage and the ALU.
- Flags unsupported encodings.

Parameters:
- RESET_CTRL, 4'b0000, value loaded into alu_ctrl on reset.
- ILLEGAL_CTRL, 4'b1111, value driven on alu_ctrl for unsupported encodings.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- en  input  1  register update enable; 0 holds outputs.
- alu_op  input  2  ALUOp from main control: 00 load/store, 01 branch, 10 R-type, 11 reserved.
- funct  input  6  instruction bits [5:0]; only funct[3:0] is decoded.
- alu_ctrl  output  4  ALU operation select (registered).
- illegal  output  1  high when the registered encoding is unsupported.

Behaviour:
- Reset: when rst_n is low, alu_ctrl = RESET_CTRL and illegal = 0 immediately, regardless of clk. Release takes effect at the next rising edge.
- Latency: one cycle. The decode of alu_op/funct sampled at rising edge N is visible after edge N.
- Enable: en = 0 holds alu_ctrl and illegal unchanged. Reset overrides en.
- Decode table (combinational, then registered):
  - alu_op 00: 0010 (add); funct ignored; illegal = 0.
  - alu_op 01: 0110 (subtract); funct ignored; illegal = 0.
  - alu_op 10, funct[3:0] 0000: 0010 (add).
  - alu_op 10, funct[3:0] 0010: 0110 (sub).
  - alu_op 10, funct[3:0] 0100: 0000 (and).
  - alu_op 10, funct[3:0] 0101: 0001 (or).
  - alu_op 10, funct[3:0] 0111: 1100 (nor).
  - alu_op 10, funct[3:0] 1010: 0111 (set-on-less-than).
  - alu_op 10, any other funct[3:0]: ILLEGAL_CTRL; illegal = 1.
  - alu_op 11: ILLEGAL_CTRL; illegal = 1.
- funct[5:4] is don't-care in all cases. X/Z on funct[5:4] must not propagate to the outputs. The decode must be written so these bits are not referenced at all.
- X or Z on funct[3:0] when alu_op is 00 or 01 must not affect the outputs.
- The decoder is purely combinational up to the register. There is no other state.
- Reset asserted mid-operation clears the outputs within the same time step. The first post-reset edge with en = 1 loads the new decode.

Test Plan:
- Reset: rst_n = 0 with no clock edge -> alu_ctrl = 0000, illegal = 0. Release, en = 1, alu_op = 00, funct = 6'bxx0000, one edge -> alu_ctrl = 0010.
- Funct ignored: alu_op = 00 with funct = xx0010, then alu_op = 01 with funct = xx0000 and xx0010 -> 0010, then 0110, 0110, each one cycle after its edge; illegal = 0.
- R-type sweep: alu_op = 10 with funct = xx0000, xx0010, xx0100, xx0101, xx0111, xx1010 on consecutive edges -> 0010, 0110, 0000, 0001, 1100, 0111 with one-cycle lag; no X on the outputs.
- Illegal: alu_op = 10 with funct = 100011, then alu_op = 11 with funct = 100000 -> alu_ctrl = 1111, illegal = 1 for both.
- Hold: load alu_op = 10, funct = 100100 (-> 0000). Set en = 0 and drive alu_op = 01 for 3 edges -> alu_ctrl stays 0000. Set en = 1 -> 0110 after the next edge.
- Async reset mid-stream: during the R-type sweep, pulse rst_n low between edges -> outputs go to 0000/0 without an edge, then resume decoding after release.
